// File: rtl/scan_fifo.sv
// scan_fifo: result buffer between the counter and the NIOS readout.
// Each rising edge of stop_step captures {time_in, signals_in} into a FIFO.
// NIOS pops entries with rd_req. A two-register window on the shared
// addr/data bus reports status and accepts flush / clear-overflow commands.
module scan_fifo #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] BASE_ADDR  = 8'h40
) (
  input  logic                  clock50Mhz,
  input  logic                  reset,
  input  logic [7:0]            addr,
  input  logic [7:0]            data,
  input  logic                  write,
  output logic [7:0]            data_out,
  input  logic                  stop_step,
  input  logic [31:0]           time_in,
  input  logic [31:0]           signals_in,
  input  logic                  rd_req,
  output logic [31:0]           rd_time,
  output logic [31:0]           rd_signals,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [7:0]            DROP_ADDR = BASE_ADDR + 8'd1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO  = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   LVL_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [63:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  stop_q;
  logic [7:0]            drop_cnt;

  logic                  capture_ev;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  reg_sel;
  logic                  flush;
  logic                  clr;
  logic [DEPTH_LOG2:0]   level_next;
  logic [7:0]            level_ext;
  logic                  unused_bits;

  // Decode capture, pop, drop and register commands for this cycle.
  always_comb begin
    capture_ev = stop_step & ~stop_q;
    // Pop sees the pre-edge empty flag, so a capture into an empty FIFO
    // cannot be popped in the same cycle.
    pop        = rd_req & ~empty;
    // At full, a same-cycle pop frees the slot the capture lands in.
    push       = capture_ev & (~full | pop);
    drop       = capture_ev & ~push;
    reg_sel    = write & (addr == BASE_ADDR);
    flush      = reg_sel & data[0];
    clr        = reg_sel & data[1];
    case ({push, pop})
      2'b10:   level_next = level + LVL_ONE;
      2'b01:   level_next = level - LVL_ONE;
      default: level_next = level;
    endcase
  end

  // Previous stop_step level for rising-edge detection; cleared by reset so
  // a level held high across reset release produces one capture.
  always_ff @(posedge clock50Mhz) begin
    if (!reset) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= stop_step;
    end
  end

  // Entry storage; deliberately not reset.
  always_ff @(posedge clock50Mhz) begin
    if (reset && !flush && push) begin
      mem[wptr] <= {time_in, signals_in};
    end
  end

  // Pointers, occupancy flags and the popped-data output registers.
  always_ff @(posedge clock50Mhz) begin
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      level      <= LVL_ZERO;
      empty      <= 1'b1;
      full       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_time    <= 32'h0000_0000;
      rd_signals <= 32'h0000_0000;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= LVL_ZERO;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr                  <= rptr + PTR_ONE;
        {rd_time, rd_signals} <= mem[rptr];
      end
      rd_valid <= pop;
      level    <= level_next;
      empty    <= (level_next == LVL_ZERO);
      full     <= (level_next == LVL_FULL);
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop in the same
  // cycle as a clear command wins over the clear.
  always_ff @(posedge clock50Mhz) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (flush) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end else begin
        drop_cnt <= drop_cnt;
      end
    end else if (clr) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      overflow <= overflow;
      drop_cnt <= drop_cnt;
    end
  end

  // Combinational register read mux for the top-level data selector.
  always_comb begin
    level_ext = 8'(level);
    case (addr)
      BASE_ADDR: data_out = {overflow, full, empty, level_ext[4:0]};
      DROP_ADDR: data_out = drop_cnt;
      default:   data_out = 8'h00;
    endcase
  end

  assign unused_bits = ^{data[7:2], level_ext[7:5]};

endmodule

// File: tb/tb_scan_fifo.sv
// Directed self-checking bench for scan_fifo (DEPTH_LOG2=4, BASE_ADDR=8'h40).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_scan_fifo;

  localparam logic [7:0] BA = 8'h40;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr;
  logic [7:0]  data;
  logic        write;
  logic [7:0]  data_out;
  logic        stop_step;
  logic [31:0] time_in;
  logic [31:0] signals_in;
  logic        rd_req;
  logic [31:0] rd_time;
  logic [31:0] rd_signals;
  logic        rd_valid;
  logic [4:0]  level;
  logic        full;
  logic        empty;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  scan_fifo #(.DEPTH_LOG2(4), .BASE_ADDR(BA)) dut (
    .clock50Mhz(clk), .reset(reset), .addr(addr), .data(data), .write(write),
    .data_out(data_out), .stop_step(stop_step), .time_in(time_in),
    .signals_in(signals_in), .rd_req(rd_req), .rd_time(rd_time),
    .rd_signals(rd_signals), .rd_valid(rd_valid), .level(level), .full(full),
    .empty(empty), .overflow(overflow)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic capture(input logic [31:0] t, input logic [31:0] s);
    time_in = t; signals_in = s; stop_step = 1'b1;
    step();
    stop_step = 1'b0;
    step();
  endtask

  task automatic flush_fifo();
    addr = BA; data = 8'h01; write = 1'b1;
    step();
    write = 1'b0; data = 8'h00;
  endtask

  task automatic drain(input int n);
    rd_req = 1'b1;
    repeat (n) step();
    rd_req = 1'b0;
    step();
  endtask

  task automatic pop_expect(input logic [31:0] et, input logic [31:0] es, input string tag);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_time !== et || rd_signals !== es) begin
      n_fail++;
      $display("FAIL %s: got valid=%b time=%h sig=%h want valid=1 time=%h sig=%h",
               tag, rd_valid, rd_time, rd_signals, et, es);
    end
    step();
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: rd_valid got %b want 0", tag, rd_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; addr = 8'h00; data = 8'h00; write = 1'b0; stop_step = 1'b0;
    time_in = 32'h0; signals_in = 32'h0; rd_req = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    n_cmp++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
        rd_valid !== 1'b0 || rd_time !== 32'h0 || rd_signals !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got lvl=%0d e=%b f=%b ov=%b v=%b t=%h s=%h want 0/1/0/0/0/0/0",
               level, empty, full, overflow, rd_valid, rd_time, rd_signals);
    end
    addr = BA; #1;
    n_cmp++;
    if (data_out !== 8'h20) begin
      n_fail++;
      $display("FAIL reset_status: got %h want 20", data_out);
    end
    addr = BA + 8'd1; #1;
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dropcnt: got %h want 00", data_out);
    end
    addr = 8'h13; #1;
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL other_addr_read: got %h want 00", data_out);
    end
  endtask

  task automatic test_single();
    time_in = 32'h0000_1234; signals_in = 32'h0000_00AB; stop_step = 1'b1;
    repeat (3) step();
    stop_step = 1'b0;
    step();
    n_cmp++;
    if (level !== 5'd1 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL single_level: got lvl=%0d e=%b want 1/0", level, empty);
    end
    pop_expect(32'h0000_1234, 32'h0000_00AB, "single_pop");
    n_cmp++;
    if (empty !== 1'b1 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL single_empty: got e=%b lvl=%0d want 1/0", empty, level);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 18; i++) capture(32'(i), 32'(i) + 32'h100);
    n_cmp++;
    if (full !== 1'b1 || overflow !== 1'b1 || level !== 5'd16) begin
      n_fail++;
      $display("FAIL fill_flags: got f=%b ov=%b lvl=%0d want 1/1/16", full, overflow, level);
    end
    addr = BA + 8'd1; #1;
    n_cmp++;
    if (data_out !== 8'd2) begin
      n_fail++;
      $display("FAIL fill_dropcnt: got %h want 02", data_out);
    end
    addr = BA; #1;
    n_cmp++;
    if (data_out !== 8'hD0) begin
      n_fail++;
      $display("FAIL fill_status: got %h want D0", data_out);
    end
    for (int i = 0; i < 16; i++) pop_expect(32'(i), 32'(i) + 32'h100, "fill_pop");
    n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_drained: got e=%b f=%b want 1/0", empty, full);
    end
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_time !== 32'd15 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL empty_pop: got v=%b t=%h lvl=%0d want 0/0000000f/0", rd_valid, rd_time, level);
    end
    step();
  endtask

  task automatic test_simul_full();
    flush_fifo();
    step();
    for (int i = 0; i < 16; i++) capture(32'd100 + 32'(i), 32'h5000 + 32'(i));
    time_in = 32'd200; signals_in = 32'h0000_0200; stop_step = 1'b1; rd_req = 1'b1;
    step();
    stop_step = 1'b0; rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_time !== 32'd100 || level !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_full: got v=%b t=%0d lvl=%0d ov=%b f=%b want 1/100/16/0/1",
               rd_valid, rd_time, level, overflow, full);
    end
    step();
    for (int i = 1; i < 16; i++) pop_expect(32'd100 + 32'(i), 32'h5000 + 32'(i), "simul_pop");
    pop_expect(32'd200, 32'h0000_0200, "simul_last");
  endtask

  task automatic test_simul_empty();
    time_in = 32'h55; signals_in = 32'h66; stop_step = 1'b1; rd_req = 1'b1;
    step();
    stop_step = 1'b0; rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0 || level !== 5'd1) begin
      n_fail++;
      $display("FAIL simul_empty: got v=%b lvl=%0d want 0/1", rd_valid, level);
    end
    step();
    pop_expect(32'h55, 32'h66, "simul_empty_pop");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      capture(32'(i) * 32'd3 + 32'd7, ~(32'(i) * 32'd3 + 32'd7));
      n_cmp++;
      if (level !== 5'd1 || empty !== 1'b0 || full !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_lvl1: iter %0d got lvl=%0d e=%b f=%b want 1/0/0", i, level, empty, full);
      end
      pop_expect(32'(i) * 32'd3 + 32'd7, ~(32'(i) * 32'd3 + 32'd7), "wrap_pop");
      n_cmp++;
      if (level !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_lvl0: iter %0d got lvl=%0d e=%b ov=%b want 0/1/0", i, level, empty, overflow);
      end
    end
  endtask

  task automatic test_flush_clear();
    flush_fifo();
    step();
    for (int i = 0; i < 18; i++) capture(32'(i), 32'h0);
    // Drop and clear in the same cycle: drop wins.
    stop_step = 1'b1; addr = BA; data = 8'h02; write = 1'b1;
    step();
    stop_step = 1'b0; write = 1'b0; data = 8'h00;
    step();
    addr = BA + 8'd1; #1;
    n_cmp++;
    if (overflow !== 1'b1 || data_out !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_wins: got ov=%b cnt=%h want 1/01", overflow, data_out);
    end
    drain(11);
    addr = BA + 8'd2; data = 8'h01; write = 1'b1;
    step();
    write = 1'b0; data = 8'h00;
    n_cmp++;
    if (level !== 5'd5 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL other_addr_write: got lvl=%0d ov=%b want 5/1", level, overflow);
    end
    addr = BA; data = 8'h02; write = 1'b1;
    step();
    write = 1'b0; data = 8'h00;
    addr = BA + 8'd1; #1;
    n_cmp++;
    if (overflow !== 1'b0 || level !== 5'd5 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL clear_ovf: got ov=%b lvl=%0d cnt=%h want 0/5/00", overflow, level, data_out);
    end
    addr = BA; data = 8'h01; write = 1'b1; stop_step = 1'b1; time_in = 32'hDEAD;
    step();
    write = 1'b0; data = 8'h00; stop_step = 1'b0;
    n_cmp++;
    if (level !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_capture: got lvl=%0d e=%b v=%b want 0/1/0", level, empty, rd_valid);
    end
    step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_lost: rd_valid got %b want 0", rd_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) capture(32'(i), 32'(i));
    rd_req = 1'b1; reset = 1'b0;
    step();
    reset = 1'b1; rd_req = 1'b0;
    addr = BA; #1;
    n_cmp++;
    if (rd_valid !== 1'b0 || level !== 5'd0 || empty !== 1'b1 || data_out !== 8'h20) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b lvl=%0d e=%b st=%h want 0/0/1/20", rd_valid, level, empty, data_out);
    end
    // stop_step held high across reset release: exactly one capture.
    stop_step = 1'b1; reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    n_cmp++;
    if (level !== 5'd1) begin
      n_fail++;
      $display("FAIL held_capture: got lvl=%0d want 1", level);
    end
    step(); step();
    n_cmp++;
    if (level !== 5'd1) begin
      n_fail++;
      $display("FAIL held_single: got lvl=%0d want 1", level);
    end
    stop_step = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_simul_full();
    test_simul_empty();
    test_wrap();
    test_flush_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
